// File: rtl/mem_stage_if.sv
// EX/MEM-side inputs and MEM/WB-side outputs of the memory stage, bundled
// for connection; signal names match the legacy flat port names.
interface mem_stage_if;
  logic [31:0] mem_stage_str_M_i;
  logic [31:0] mem_stage_pc4_M_i;
  logic [31:0] mem_stage_alo_M_i;
  logic [31:0] mem_stage_rtd_M_i;
  logic [31:0] mem_stage_str_W_o;
  logic [31:0] mem_stage_pc4_W_o;
  logic [31:0] mem_stage_alo_W_o;
  logic [31:0] mem_stage_dmo_W_o;
  logic        mem_stage_exc_W_o;

  modport master (
    output mem_stage_str_M_i, mem_stage_pc4_M_i, mem_stage_alo_M_i, mem_stage_rtd_M_i,
    input  mem_stage_str_W_o, mem_stage_pc4_W_o, mem_stage_alo_W_o, mem_stage_dmo_W_o,
           mem_stage_exc_W_o
  );

  modport slave (
    input  mem_stage_str_M_i, mem_stage_pc4_M_i, mem_stage_alo_M_i, mem_stage_rtd_M_i,
    output mem_stage_str_W_o, mem_stage_pc4_W_o, mem_stage_alo_W_o, mem_stage_dmo_W_o,
           mem_stage_exc_W_o
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: word-organised data memory with byte/half/word access,
// load extension, misalignment flag, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned ADDR_W = 12
) (
  input logic       mem_stage_clk_M_i,
  input logic       mem_stage_clr_M_i,
  mem_stage_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_LW,
    OP_LH,
    OP_LHU,
    OP_LB,
    OP_LBU,
    OP_SW,
    OP_SH,
    OP_SB
  } mem_op_e;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       str;
  logic [31:0]       alo;
  logic [31:0]       rtd;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  mem_op_e           op;

  logic              misaligned;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rword;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  logic [31:0]       str_q = '0;
  logic [31:0]       pc4_q = '0;
  logic [31:0]       alo_q = '0;
  logic [31:0]       dmo_q = '0;
  logic              exc_q = 1'b0;

  logic              unused_alo;

  assign str  = bus.mem_stage_str_M_i;
  assign alo  = bus.mem_stage_alo_M_i;
  assign rtd  = bus.mem_stage_rtd_M_i;
  assign idx  = alo[ADDR_W+1:2];
  assign lane = alo[1:0];

  // Address bits above the word index are dropped, so accesses wrap.
  assign unused_alo = ^alo[31:ADDR_W+2];

  always_comb begin
    op = OP_NONE;
    unique case (str[31:26])
      6'h23:   op = OP_LW;
      6'h21:   op = OP_LH;
      6'h25:   op = OP_LHU;
      6'h20:   op = OP_LB;
      6'h24:   op = OP_LBU;
      6'h2B:   op = OP_SW;
      6'h29:   op = OP_SH;
      6'h28:   op = OP_SB;
      default: op = OP_NONE;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    unique case (op)
      OP_LW, OP_SW:         misaligned = (lane != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = lane[0];
      default:              misaligned = 1'b0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be    = '0;
    wdata = rtd;
    if (!misaligned) begin
      unique case (op)
        OP_SW: be = '1;
        OP_SH: begin
          be    = lane[1] ? 4'b1100 : 4'b0011;
          wdata = {2{rtd[15:0]}};
        end
        OP_SB: begin
          be    = 4'b0001 << lane;
          wdata = {4{rtd[7:0]}};
        end
        default: be = '0;
      endcase
    end
  end

  always_comb begin
    rword     = mem[idx];
    byte_sel  = rword[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? rword[31:16] : rword[15:0];
    load_data = '0;
    if (!misaligned) begin
      unique case (op)
        OP_LW:   load_data = rword;
        OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
        OP_LHU:  load_data = {16'h0000, half_sel};
        OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
        OP_LBU:  load_data = {24'h000000, byte_sel};
        default: load_data = '0;
      endcase
    end
  end

  always_ff @(posedge mem_stage_clk_M_i) begin
    if (mem_stage_clr_M_i) begin
      str_q <= '0;
      pc4_q <= '0;
      alo_q <= '0;
      dmo_q <= '0;
      exc_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      str_q <= str;
      pc4_q <= bus.mem_stage_pc4_M_i;
      alo_q <= alo;
      dmo_q <= load_data;
      exc_q <= misaligned;
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_stage_str_W_o = str_q;
  assign bus.mem_stage_pc4_W_o = pc4_q;
  assign bus.mem_stage_alo_W_o = alo_q;
  assign bus.mem_stage_dmo_W_o = dmo_q;
  assign bus.mem_stage_exc_W_o = exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: reset, word/byte/half round trips,
// misalignment, reset-vs-store priority, address wrap and non-memory ops.
module tb_mem_stage;

  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] SW  = 6'h2B;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] NOP = 6'h00;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] pc = 32'h0000_1000;
  logic [31:0] exp_str;
  logic [31:0] exp_pc4;

  mem_stage_if bus ();

  mem_stage #(.ADDR_W(12)) dut (
    .mem_stage_clk_M_i(clk),
    .mem_stage_clr_M_i(clr),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  // Present one instruction for one M cycle, then step just past the edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] alo,
                       input logic [31:0] rtd, input logic c);
    exp_str = {op, 26'h0ABCDE};
    pc      = pc + 32'd4;
    exp_pc4 = pc;
    bus.mem_stage_str_M_i = exp_str;
    bus.mem_stage_pc4_M_i = exp_pc4;
    bus.mem_stage_alo_M_i = alo;
    bus.mem_stage_rtd_M_i = rtd;
    clr = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    issue(SW, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
    issue(SW, 32'h0000_0FFC, 32'h1357_9BDF, 1'b0);
    issue(SW, 32'h0000_0000, 32'h2468_ACE0, 1'b0);
    issue(LW, 32'h0000_0040, 32'h0, 1'b1);
    compared++;
    if ({bus.mem_stage_str_W_o, bus.mem_stage_pc4_W_o, bus.mem_stage_alo_W_o,
         bus.mem_stage_dmo_W_o, bus.mem_stage_exc_W_o} !== 129'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: str=%h pc4=%h alo=%h dmo=%h exc=%b, want all 0",
               bus.mem_stage_str_W_o, bus.mem_stage_pc4_W_o, bus.mem_stage_alo_W_o,
               bus.mem_stage_dmo_W_o, bus.mem_stage_exc_W_o);
    end
    issue(LW, 32'h0000_0000, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_lw_0x0: got %h want 00000000", bus.mem_stage_dmo_W_o);
    end
    issue(LW, 32'h0000_0040, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_lw_0x40: got %h want 00000000", bus.mem_stage_dmo_W_o);
    end
    issue(LW, 32'h0000_0FFC, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_lw_0xffc: got %h want 00000000", bus.mem_stage_dmo_W_o);
    end
  endtask

  task automatic test_word();
    issue(SW, 32'h0000_0010, 32'h1234_5678, 1'b0);
    compared++;
    if (bus.mem_stage_str_W_o !== exp_str || bus.mem_stage_pc4_W_o !== exp_pc4 ||
        bus.mem_stage_alo_W_o !== 32'h0000_0010 || bus.mem_stage_exc_W_o !== 1'b0) begin
      mismatched++;
      $display("FAIL sw_passthru: str=%h pc4=%h alo=%h exc=%b, want %h %h 00000010 0",
               bus.mem_stage_str_W_o, bus.mem_stage_pc4_W_o, bus.mem_stage_alo_W_o,
               bus.mem_stage_exc_W_o, exp_str, exp_pc4);
    end
    issue(LW, 32'h0000_0010, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h1234_5678 || bus.mem_stage_exc_W_o !== 1'b0 ||
        bus.mem_stage_str_W_o !== exp_str) begin
      mismatched++;
      $display("FAIL lw_roundtrip: dmo=%h exc=%b str=%h, want 12345678 0 %h",
               bus.mem_stage_dmo_W_o, bus.mem_stage_exc_W_o, bus.mem_stage_str_W_o, exp_str);
    end
  endtask

  task automatic test_lanes();
    issue(SB, 32'h0000_0011, 32'h0000_00AB, 1'b0);
    issue(LW, 32'h0000_0010, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h1234_AB78) begin
      mismatched++;
      $display("FAIL sb_word: got %h want 1234ab78", bus.mem_stage_dmo_W_o);
    end
    issue(LB, 32'h0000_0011, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'hFFFF_FFAB) begin
      mismatched++;
      $display("FAIL lb_sign: got %h want ffffffab", bus.mem_stage_dmo_W_o);
    end
    issue(LBU, 32'h0000_0011, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0000_00AB) begin
      mismatched++;
      $display("FAIL lbu_zero: got %h want 000000ab", bus.mem_stage_dmo_W_o);
    end
    issue(SH, 32'h0000_0012, 32'h0000_8001, 1'b0);
    issue(LW, 32'h0000_0010, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h8001_AB78) begin
      mismatched++;
      $display("FAIL sh_word: got %h want 8001ab78", bus.mem_stage_dmo_W_o);
    end
    issue(LH, 32'h0000_0012, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'hFFFF_8001) begin
      mismatched++;
      $display("FAIL lh_sign: got %h want ffff8001", bus.mem_stage_dmo_W_o);
    end
    issue(LHU, 32'h0000_0012, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0000_8001) begin
      mismatched++;
      $display("FAIL lhu_zero: got %h want 00008001", bus.mem_stage_dmo_W_o);
    end
    issue(LB, 32'h0000_0010, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0000_0078) begin
      mismatched++;
      $display("FAIL lb_lane0: got %h want 00000078", bus.mem_stage_dmo_W_o);
    end
  endtask

  task automatic test_misalign();
    issue(SW, 32'h0000_0022, 32'hFFFF_FFFF, 1'b0);
    compared++;
    if (bus.mem_stage_exc_W_o !== 1'b1) begin
      mismatched++;
      $display("FAIL sw_mis_exc: got %b want 1", bus.mem_stage_exc_W_o);
    end
    issue(LW, 32'h0000_0020, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0 || bus.mem_stage_exc_W_o !== 1'b0) begin
      mismatched++;
      $display("FAIL sw_mis_nowrite: dmo=%h exc=%b want 00000000 0",
               bus.mem_stage_dmo_W_o, bus.mem_stage_exc_W_o);
    end
    issue(LH, 32'h0000_0013, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0 || bus.mem_stage_exc_W_o !== 1'b1) begin
      mismatched++;
      $display("FAIL lh_mis: dmo=%h exc=%b want 00000000 1",
               bus.mem_stage_dmo_W_o, bus.mem_stage_exc_W_o);
    end
    issue(LW, 32'h0000_0012, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0 || bus.mem_stage_exc_W_o !== 1'b1) begin
      mismatched++;
      $display("FAIL lw_mis: dmo=%h exc=%b want 00000000 1",
               bus.mem_stage_dmo_W_o, bus.mem_stage_exc_W_o);
    end
  endtask

  task automatic test_reset_store();
    issue(SW, 32'h0000_0030, 32'h0000_0005, 1'b1);
    issue(LW, 32'h0000_0030, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0) begin
      mismatched++;
      $display("FAIL clr_beats_store: got %h want 00000000", bus.mem_stage_dmo_W_o);
    end
    issue(SW, 32'h0000_4010, 32'hCAFE_F00D, 1'b0);
    issue(LW, 32'h0000_0010, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'hCAFE_F00D) begin
      mismatched++;
      $display("FAIL addr_wrap: got %h want cafef00d", bus.mem_stage_dmo_W_o);
    end
  endtask

  task automatic test_nonmem();
    issue(NOP, 32'h0000_0050, 32'h0000_0007, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0 || bus.mem_stage_exc_W_o !== 1'b0 ||
        bus.mem_stage_alo_W_o !== 32'h0000_0050 || bus.mem_stage_str_W_o !== exp_str) begin
      mismatched++;
      $display("FAIL nonmem_out: dmo=%h exc=%b alo=%h str=%h want 00000000 0 00000050 %h",
               bus.mem_stage_dmo_W_o, bus.mem_stage_exc_W_o, bus.mem_stage_alo_W_o,
               bus.mem_stage_str_W_o, exp_str);
    end
    issue(LW, 32'h0000_0050, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0) begin
      mismatched++;
      $display("FAIL nonmem_nowrite: got %h want 00000000", bus.mem_stage_dmo_W_o);
    end
  endtask

  task automatic test_back_to_back();
    issue(SW, 32'h0000_0080, 32'hA5A5_0001, 1'b0);
    issue(SW, 32'h0000_0084, 32'h5A5A_0002, 1'b0);
    issue(LW, 32'h0000_0080, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'hA5A5_0001) begin
      mismatched++;
      $display("FAIL b2b_lw0: got %h want a5a50001", bus.mem_stage_dmo_W_o);
    end
    issue(LHU, 32'h0000_0086, 32'h0, 1'b0);
    compared++;
    if (bus.mem_stage_dmo_W_o !== 32'h0000_5A5A || bus.mem_stage_pc4_W_o !== exp_pc4) begin
      mismatched++;
      $display("FAIL b2b_lhu: dmo=%h pc4=%h want 00005a5a %h",
               bus.mem_stage_dmo_W_o, bus.mem_stage_pc4_W_o, exp_pc4);
    end
  endtask

  initial begin
    bus.mem_stage_str_M_i = '0;
    bus.mem_stage_pc4_M_i = '0;
    bus.mem_stage_alo_M_i = '0;
    bus.mem_stage_rtd_M_i = '0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    test_reset();
    test_word();
    test_lanes();
    test_misalign();
    test_reset_store();
    test_nonmem();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline; consumes the EX/MEM register outputs (instruction, PC+4, ALU result, forwarded rt data).
- Contains a word-organised data memory with byte/halfword/word stores, load byte-select and extension, and misalignment detection.
- Registers everything into the MEM/WB pipeline register that feeds write-back.

Parameters:
- ADDR_W, 12, word-index width; memory depth = 2^ADDR_W 32-bit words (16 KB).

Ports:
- mem_stage_clk_M_i  input  1  clock; all state updates on rising edge.
- mem_stage_clr_M_i  input  1  synchronous active-high reset; also clears data memory.
- mem_stage_str_M_i  input  32  instruction in M stage.
- mem_stage_pc4_M_i  input  32  PC+4 of that instruction.
- mem_stage_alo_M_i  input  32  ALU result, used as byte address for loads/stores.
- mem_stage_rtd_M_i  input  32  store data (forwarded rt).
- mem_stage_str_W_o  output  32  registered instruction to W.
- mem_stage_pc4_W_o  output  32  registered PC+4 to W.
- mem_stage_alo_W_o  output  32  registered ALU result to W.
- mem_stage_dmo_W_o  output  32  registered, extended load data to W.
- mem_stage_exc_W_o  output  1  registered misaligned-access flag to W.

Behaviour:
- Reset: synchronous, active-high. Clock and reset are the single clock and synchronous active-high reset already decided for this block.
  - All W outputs are 0 after the edge where clr=1, and at power-up (initial 0).
  - Every memory word is set to 0 at that same edge.
  - clr has priority over any store in that cycle: the store is discarded.
- Decode uses opcode str[31:26]:
  - Stores: sw 0x2B, sh 0x29, sb 0x28.
  - Loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - Any other opcode is a non-memory op.
- Addressing:
  - Word index = alo[ADDR_W+1:2]; bits above it are ignored, so addresses wrap modulo the memory size.
  - Byte lane = alo[1:0], little-endian: lane 0 = bits [7:0].
- Alignment:
  - lw/sw require alo[1:0]=00.
  - lh/lhu/sh require alo[0]=0.
  - Byte accesses are always aligned.
- Store:
  - Written at the rising edge ending the instruction's M cycle, using byte enables.
  - sw writes all 4 bytes with rtd.
  - sh writes lanes {1,0} or {3,2} with rtd[15:0].
  - sb writes one lane with rtd[7:0].
  - Unwritten bytes keep their value.
  - A misaligned store writes nothing.
- Load:
  - Memory read is combinational from the current word.
  - Select and extend: lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
  - The result is captured into dmo_W_o at the same edge, so latency is 1 cycle, matching the other W outputs.
  - A misaligned load gives dmo=0.
  - For non-load ops dmo = 0.
- exc_W_o: 1 for exactly the W cycle of a misaligned load/store, else 0.
- Pass-through: str, pc4 and alo are registered unchanged, 1-cycle latency.
- Store followed by load, same address, consecutive cycles: the load returns the new data; no forwarding is required because the write completes at the edge before the load's M cycle.
- No stall input: the stage advances every cycle. A bubble is injected upstream as str=0, which is treated as a non-memory op.

Test Plan:
- Reset: clr=1 for 1 cycle after arbitrary traffic -> all W outputs 0; lw from 0x0, 0x40 and 0xFFC each return dmo=0.
- Word round-trip: sw rtd=0x12345678 alo=0x10, then lw alo=0x10 in the next cycle -> dmo=0x12345678, exc=0; str/pc4/alo appear at W one cycle after M.
- Byte/half lanes, with word 0x10 = 0x12345678:
  - sb rtd=0xAB alo=0x11 -> word 0x1234AB78.
  - lb 0x11 -> 0xFFFFFFAB; lbu 0x11 -> 0x000000AB.
  - sh rtd=0x8001 alo=0x12 -> word 0x8001AB78.
  - lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001.
- Misalignment: sw alo=0x22 rtd=0xFFFFFFFF, then lw 0x20 -> word unchanged (0), exc=1 on the sw W cycle only; lh alo=0x13 -> dmo=0, exc=1.
- Reset vs store: sw alo=0x30 rtd=5 with clr=1 in the same cycle -> lw 0x30 returns 0; wrap check: sw alo=0x4010 (ADDR_W=12) then lw 0x10 returns the same data.
- Non-memory op: str opcode 0x00 with alo=0x50, rtd=7 -> memory unchanged, dmo=0, exc=0, alo_W=0x50.
